// File: rtl/space_invaders_pkg.sv
// Shared Space Invaders constants and types: screen geometry, player row, and player-missile tuning.
// Holds no logic; the player, player_bullet and color_mapper blocks import it.
package space_invaders_pkg;

    typedef enum logic [1:0] {BS_IDLE, BS_FLYING, BS_COOLDOWN} bullet_state_t;

    localparam logic [1:0] ST_IDLE     = 2'(BS_IDLE);
    localparam logic [1:0] ST_FLYING   = 2'(BS_FLYING);
    localparam logic [1:0] ST_COOLDOWN = 2'(BS_COOLDOWN);

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam logic [9:0]  PLAYER_Y = 10'd450;

    localparam logic [9:0] BULLET_Y_START  = 10'd440;
    localparam logic [9:0] BULLET_Y_MIN    = 10'd0;
    localparam logic [9:0] BULLET_Y_STEP   = 10'd4;
    localparam logic [7:0] COOLDOWN_FRAMES = 8'd8;

endpackage

// File: rtl/player_bullet_if.sv
// Player-missile bundle: fire request and hit report in, bullet position and status out.
// The master side belongs to the player and collision logic; the slave side is player_bullet.
interface player_bullet_if;
    logic       shoot_bullet;
    logic [9:0] player_X;
    logic       bullet_hit;
    logic [9:0] bullet_X;
    logic [9:0] bullet_Y;
    logic       bullet_active;
    logic       hit_pulse;

    modport master (
        output shoot_bullet, player_X, bullet_hit,
        input  bullet_X, bullet_Y, bullet_active, hit_pulse
    );

    modport slave (
        input  shoot_bullet, player_X, bullet_hit,
        output bullet_X, bullet_Y, bullet_active, hit_pulse
    );
endinterface

// File: rtl/player_bullet.sv
// Single player missile: launches at player_X, climbs one step per frame, and retires on a hit or at the top. It accepts no backpressure.
// All outputs are registered, and a launch shows on the same edge as the shot. Define BULLET_COOLDOWN_EN to lock out re-fire for a few frames.
module player_bullet
    import space_invaders_pkg::*;
#(
    parameter logic [9:0] Y_START = BULLET_Y_START,
    parameter logic [9:0] Y_MIN   = BULLET_Y_MIN,
    parameter logic [9:0] Y_STEP  = BULLET_Y_STEP
`ifdef BULLET_COOLDOWN_EN
    ,
    parameter logic [7:0] CD_FRAMES = COOLDOWN_FRAMES
`endif
) (
    input  logic            frame_clk,
    input  logic            Reset,
    player_bullet_if.slave  bif
);

`ifdef BULLET_COOLDOWN_EN
    localparam logic [1:0] ST_RETIRE = ST_COOLDOWN;
    // Zero frames is treated as a single frame of lockout.
    localparam logic [7:0] CD_LOAD = (CD_FRAMES == 8'd0) ? 8'd0 : (CD_FRAMES - 8'd1);
    logic [7:0] cd_cnt;
`else
    localparam logic [1:0] ST_RETIRE = ST_IDLE;
`endif

    logic [1:0] state;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       active_q;
    logic       hit_q;
    logic       off_top;

    // Compare at 11 bits before stepping, so Y never wraps past the top.
    assign off_top = ({1'b0, y_q} < ({1'b0, Y_MIN} + {1'b0, Y_STEP}));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            x_q      <= 10'd0;
            y_q      <= Y_START;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
            cd_cnt   <= 8'd0;
`endif
        end else begin
            hit_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bif.shoot_bullet) begin
                        x_q      <= bif.player_X;
                        y_q      <= Y_START;
                        active_q <= 1'b1;
                        state    <= ST_FLYING;
                    end
                end
                ST_FLYING: begin
                    if (bif.bullet_hit) begin
                        active_q <= 1'b0;
                        hit_q    <= 1'b1;
                        state    <= ST_RETIRE;
`ifdef BULLET_COOLDOWN_EN
                        cd_cnt   <= CD_LOAD;
`endif
                    end else if (off_top) begin
                        active_q <= 1'b0;
                        state    <= ST_RETIRE;
`ifdef BULLET_COOLDOWN_EN
                        cd_cnt   <= CD_LOAD;
`endif
                    end else begin
                        y_q <= y_q - Y_STEP;
                    end
                end
`ifdef BULLET_COOLDOWN_EN
                ST_COOLDOWN: begin
                    if (cd_cnt == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - 8'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bif.bullet_X      = x_q;
    assign bif.bullet_Y      = y_q;
    assign bif.bullet_active = active_q;
    assign bif.hit_pulse     = hit_q;

endmodule

// File: tb/tb_player_bullet.sv
// Directed check of player_bullet: reset, launch, flight, top-of-screen retire, hit retire and re-fire lockout.
module tb_player_bullet;

    logic frame_clk;
    logic Reset;
    int   total;
    int   bad;
    logic seen_hp;

`ifdef BULLET_COOLDOWN_EN
    localparam int CD_WAIT = 9;
`else
    localparam int CD_WAIT = 0;
`endif

    player_bullet_if bif ();

    player_bullet dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bif       (bif.slave)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bif.shoot_bullet = 1'b0;
        bif.player_X     = 10'd0;
        bif.bullet_hit   = 1'b0;
        #2;
        chk("rst_active", 32'(bif.bullet_active), 32'd0);
        chk("rst_y",      32'(bif.bullet_Y),      32'd440);
        chk("rst_x",      32'(bif.bullet_X),      32'd0);
        chk("rst_hp",     32'(bif.hit_pulse),     32'd0);
        step();
        step();
        Reset = 1'b0;

        // Launch from X=320, then ten frames of flight.
        bif.player_X = 10'd320;
        bif.shoot_bullet = 1'b1;
        step();
        bif.shoot_bullet = 1'b0;
        chk("launch_x",      32'(bif.bullet_X),      32'd320);
        chk("launch_y",      32'(bif.bullet_Y),      32'd440);
        chk("launch_active", 32'(bif.bullet_active), 32'd1);
        repeat (10) step();
        chk("fly10_y", 32'(bif.bullet_Y), 32'd400);

        // An asynchronous reset mid-flight takes effect with no clock edge.
        repeat (50) step();
        chk("fly60_y", 32'(bif.bullet_Y), 32'd200);
        #2;
        Reset = 1'b1;
        #1;
        chk("midrst_active", 32'(bif.bullet_active), 32'd0);
        chk("midrst_y",      32'(bif.bullet_Y),      32'd440);
        step();
        Reset = 1'b0;

        // Unobstructed flight to the top of the screen.
        bif.player_X = 10'd100;
        bif.shoot_bullet = 1'b1;
        step();
        bif.shoot_bullet = 1'b0;
        seen_hp = 1'b0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (bif.hit_pulse) seen_hp = 1'b1;
        end
        chk("top_y",        32'(bif.bullet_Y),      32'd0);
        chk("top_active",   32'(bif.bullet_active), 32'd1);
        step();
        if (bif.hit_pulse) seen_hp = 1'b1;
        chk("top_retire",   32'(bif.bullet_active), 32'd0);
        chk("top_hold_y",   32'(bif.bullet_Y),      32'd0);
        chk("top_hold_x",   32'(bif.bullet_X),      32'd100);
        chk("top_no_hp",    32'(seen_hp),           32'd0);
        repeat (CD_WAIT) step();

        // A hit at Y=300 gives a one-frame pulse.
        bif.player_X = 10'd500;
        bif.shoot_bullet = 1'b1;
        step();
        bif.shoot_bullet = 1'b0;
        repeat (35) step();
        chk("hit_pre_y", 32'(bif.bullet_Y), 32'd300);
        bif.bullet_hit = 1'b1;
        step();
        bif.bullet_hit = 1'b0;
        chk("hit_active", 32'(bif.bullet_active), 32'd0);
        chk("hit_pulse1", 32'(bif.hit_pulse),     32'd1);
        chk("hit_hold_y", 32'(bif.bullet_Y),      32'd300);
        step();
        chk("hit_pulse2", 32'(bif.hit_pulse),     32'd0);
        repeat (CD_WAIT) step();

        // A hit is ignored while no bullet is flying.
        bif.bullet_hit = 1'b1;
        step();
        bif.bullet_hit = 1'b0;
        chk("idle_hit_hp",     32'(bif.hit_pulse),     32'd0);
        chk("idle_hit_active", 32'(bif.bullet_active), 32'd0);

        // Hit and top-of-screen on the same edge: the hit wins.
        bif.player_X = 10'd7;
        bif.shoot_bullet = 1'b1;
        step();
        bif.shoot_bullet = 1'b0;
        repeat (110) step();
        chk("both_pre_y", 32'(bif.bullet_Y), 32'd0);
        bif.bullet_hit = 1'b1;
        step();
        bif.bullet_hit = 1'b0;
        chk("both_hp",     32'(bif.hit_pulse),     32'd1);
        chk("both_active", 32'(bif.bullet_active), 32'd0);
        repeat (CD_WAIT) step();

        // Shoot held throughout flight: no relaunch, X stays fixed.
        bif.player_X = 10'd200;
        bif.shoot_bullet = 1'b1;
        step();
        chk("hold_launch_x", 32'(bif.bullet_X), 32'd200);
        bif.player_X = 10'd50;
        repeat (5) step();
        chk("hold_x", 32'(bif.bullet_X), 32'd200);
        chk("hold_y", 32'(bif.bullet_Y), 32'd420);
        bif.bullet_hit = 1'b1;
        step();
        bif.bullet_hit = 1'b0;
        chk("hold_retire", 32'(bif.bullet_active), 32'd0);
        chk("hold_hp",     32'(bif.hit_pulse),     32'd1);
`ifdef BULLET_COOLDOWN_EN
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cd_lockout", 32'(bif.bullet_active), 32'd0);
        end
`endif
        step();
        chk("refire_active", 32'(bif.bullet_active), 32'd1);
        chk("refire_x",      32'(bif.bullet_X),      32'd50);
        chk("refire_y",      32'(bif.bullet_Y),      32'd440);
        chk("refire_hp",     32'(bif.hit_pulse),     32'd0);
        bif.shoot_bullet = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
